// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
// ---------------
// UART receive front end. Synchronises the asynchronous serial line, runs a
// free-running 16x oversampling tick generator, and walks each frame through
// a start/data/stop state machine that samples every bit near its middle.
// A good frame updates data_out and pulses done_tick for one clock. A low
// stop bit pulses frame_err instead; the FSM then parks until the line goes
// high again, so a held-low (break) line cannot retrigger frames.
//
// Parameters:
//   CLK_FREQ  system clock frequency in Hz
//   BAUD      line rate in bits/s
//   DBIT      data bits per frame, LSB first (4..8)
//   SB_TICK   oversample ticks per stop bit (16 = 1 stop bit, 32 = 2)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   rx         serial line, idles high
//   data_out   last correctly framed word, held until the next good frame
//   done_tick  one-clock pulse when data_out updates
//   frame_err  one-clock pulse when the stop bit is sampled low
//   busy       high whenever the FSM is not idle

module uart_rx_sampler #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic [DBIT-1:0] data_out,
    output logic            done_tick,
    output logic            frame_err,
    output logic            busy
);

    // Divider is floored and clamped to 1 so very slow clocks still tick.
    localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_MAX   = ((SB_TICK - 1) > 15) ? (SB_TICK - 1) : 15;
    localparam int SW      = $clog2(S_MAX + 1);
    localparam int NW      = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [TW-1:0] TICK_LAST   = TW'(DIV - 1);
    localparam logic [SW-1:0] S_MID       = SW'(7);
    localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic [1:0]      sync_q, sync_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] data_q, data_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;

    logic rx_s;
    logic s_tick;

    // sync_q[1] is the metastability-safe copy of rx used for every decision.
    assign rx_s   = sync_q[1];
    assign s_tick = (tick_cnt_q == TICK_LAST);

    // Synchroniser shift and free-running tick counter; the FSM never
    // restarts the counter, so the first tick after a start edge can land
    // anywhere within one tick period.
    always_comb begin
        sync_d     = {sync_q[0], rx};
        tick_cnt_d = s_tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Frame state machine. Pulses default low so each lasts exactly one clock.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end

            // Half a bit into the start bit: a line that is high again was a
            // glitch and is dropped silently.
            ST_START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            // Bits arrive LSB first, so shift in from the top.
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        if (rx_s) begin
                            state_d = ST_IDLE;
                            data_d  = b_q;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_BREAK;
                            ferr_d  = 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; the synchroniser resets to the idle line level so no
    // false start is seen coming out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= 2'b11;
            tick_cnt_q <= '0;
            state_q    <= ST_IDLE;
            s_q        <= '0;
            n_q        <= '0;
            b_q        <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            b_q        <= b_d;
            data_q     <= data_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    assign data_out  = data_q;
    assign done_tick = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler
// ------------------
// Drives two receivers from one clock: a fast one (16 clocks per bit) for
// the directed and randomized frame tests, and one at the default rates for
// true 115200-baud timing. Each frame queues its expected outcome (a word or
// a framing error); a monitor pops the queue on every done_tick/frame_err.

module tb_uart_rx_sampler;

    localparam int F_BIT = 16;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx_f  = 1'b1;
    logic       rx_d  = 1'b1;
    logic [7:0] data_f, data_d;
    logic       done_f, done_d, ferr_f, ferr_d, busy_f, busy_d;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    exp_t       q_f[$];
    exp_t       q_d[$];
    logic [7:0] good_f = 8'h00;
    logic [7:0] good_d = 8'h00;
    int         done_cyc_prev = 0;
    int         done_cyc_last = 0;
    logic       prev_done_f = 1'b0, prev_ferr_f = 1'b0;
    logic       prev_done_d = 1'b0, prev_ferr_d = 1'b0;

    uart_rx_sampler #(
        .CLK_FREQ(1600),
        .BAUD    (100),
        .DBIT    (8),
        .SB_TICK (16)
    ) dut_fast (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx_f),
        .data_out (data_f),
        .done_tick(done_f),
        .frame_err(ferr_f),
        .busy     (busy_f)
    );

    uart_rx_sampler dut_def (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx_d),
        .data_out (data_d),
        .done_tick(done_d),
        .frame_err(ferr_d),
        .busy     (busy_d)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveRx(input bit which, input logic v, input int n);
        if (which) rx_d = v;
        else       rx_f = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame; stop_ok=0 drives a low stop bit to force a framing error.
    task automatic applyStimulus(input bit which, input logic [7:0] data,
                                 input int period, input bit stop_ok);
        exp_t e;
        e.is_err = !stop_ok;
        e.data   = data;
        if (which) q_d.push_back(e);
        else       q_f.push_back(e);
        driveRx(which, 1'b0, period);
        for (int i = 0; i < 8; i++) driveRx(which, data[i], period);
        driveRx(which, stop_ok, period);
    endtask

    task automatic waitDrain(input bit which, input int max_clks);
        int k;
        k = 0;
        while (((which ? q_d.size() : q_f.size()) != 0) && (k < max_clks)) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (which) checkOutput("drain_def", q_d.size(), 0);
        else       checkOutput("drain_fast", q_f.size(), 0);
    endtask

    task automatic monitorStep(input bit which, input logic done, input logic ferr,
                               input logic [7:0] data, input logic busy,
                               input logic prev_done, input logic prev_ferr);
        exp_t e;
        int   sz;
        sz = which ? q_d.size() : q_f.size();
        if (done || ferr) checkOutput("pulse_exclusive", {31'b0, done & ferr}, 0);
        if (done || ferr) begin
            if (sz == 0) begin
                checkOutput("unexpected_pulse", 1, 0);
            end else begin
                if (which) e = q_d.pop_front();
                else       e = q_f.pop_front();
                if (done) begin
                    checkOutput("done_width", {31'b0, prev_done}, 0);
                    checkOutput("busy_at_done", {31'b0, busy}, 0);
                    checkOutput("kind_done", {31'b0, e.is_err}, 0);
                    checkOutput("data_out", {24'b0, data}, {24'b0, e.data});
                    if (which) good_d = e.data;
                    else begin
                        good_f        = e.data;
                        done_cyc_prev = done_cyc_last;
                        done_cyc_last = cycle;
                    end
                end else begin
                    checkOutput("ferr_width", {31'b0, prev_ferr}, 0);
                    checkOutput("busy_in_break", {31'b0, busy}, 1);
                    checkOutput("kind_ferr", {31'b0, e.is_err}, 1);
                    checkOutput("data_hold", {24'b0, data},
                                {24'b0, (which ? good_d : good_f)});
                end
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            monitorStep(1'b0, done_f, ferr_f, data_f, busy_f, prev_done_f, prev_ferr_f);
            monitorStep(1'b1, done_d, ferr_d, data_d, busy_d, prev_done_d, prev_ferr_d);
        end
        prev_done_f <= done_f;
        prev_ferr_f <= ferr_f;
        prev_done_d <= done_d;
        prev_ferr_d <= ferr_d;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: run still active at time limit, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        logic [7:0] byte_v;

        // Reset state of both receivers.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_data_f", {24'b0, data_f}, 0);
        checkOutput("rst_done_f", {31'b0, done_f}, 0);
        checkOutput("rst_ferr_f", {31'b0, ferr_f}, 0);
        checkOutput("rst_busy_f", {31'b0, busy_f}, 0);
        checkOutput("rst_data_d", {24'b0, data_d}, 0);
        checkOutput("rst_busy_d", {31'b0, busy_d}, 0);
        reset = 1'b0;
        driveRx(1'b0, 1'b1, 20);

        // Single frame, busy sampled mid-frame.
        fork
            applyStimulus(1'b0, 8'h55, F_BIT, 1'b1);
            begin
                repeat (80) @(posedge clk);
                #2;
                checkOutput("t1_busy_mid", {31'b0, busy_f}, 1);
            end
        join
        waitDrain(1'b0, 100);
        checkOutput("t1_data", {24'b0, data_f}, 32'h55);
        checkOutput("t1_busy_after", {31'b0, busy_f}, 0);
        driveRx(1'b0, 1'b1, 20);

        // Back-to-back frames with no idle gap.
        applyStimulus(1'b0, 8'hA3, F_BIT, 1'b1);
        applyStimulus(1'b0, 8'h0F, F_BIT, 1'b1);
        waitDrain(1'b0, 100);
        checkOutput("t2_spacing", done_cyc_last - done_cyc_prev, 160);
        checkOutput("t2_data", {24'b0, data_f}, 32'h0F);
        driveRx(1'b0, 1'b1, 20);

        // Short low glitch rejected, then a good frame.
        driveRx(1'b0, 1'b0, 4);
        driveRx(1'b0, 1'b1, 30);
        checkOutput("t3_busy", {31'b0, busy_f}, 0);
        applyStimulus(1'b0, 8'h81, F_BIT, 1'b1);
        waitDrain(1'b0, 100);
        checkOutput("t3_data", {24'b0, data_f}, 32'h81);
        driveRx(1'b0, 1'b1, 20);

        // Framing error followed by a held-low break.
        applyStimulus(1'b0, 8'h3C, F_BIT, 1'b0);
        driveRx(1'b0, 1'b0, 200);
        checkOutput("t4_break_busy", {31'b0, busy_f}, 1);
        checkOutput("t4_data_hold", {24'b0, data_f}, 32'h81);
        waitDrain(1'b0, 10);
        driveRx(1'b0, 1'b1, 20);
        checkOutput("t4_busy_release", {31'b0, busy_f}, 0);
        applyStimulus(1'b0, 8'h81, F_BIT, 1'b1);
        waitDrain(1'b0, 100);
        checkOutput("t4_data", {24'b0, data_f}, 32'h81);
        driveRx(1'b0, 1'b1, 20);

        // Reset in the middle of data bit 4 of 0xFF.
        driveRx(1'b0, 1'b0, F_BIT);
        driveRx(1'b0, 1'b1, 4 * F_BIT + 8);
        reset = 1'b1;
        #1;
        checkOutput("t5_data", {24'b0, data_f}, 0);
        checkOutput("t5_done", {31'b0, done_f}, 0);
        checkOutput("t5_ferr", {31'b0, ferr_f}, 0);
        checkOutput("t5_busy", {31'b0, busy_f}, 0);
        good_f = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        driveRx(1'b0, 1'b1, 20);
        applyStimulus(1'b0, 8'h7E, F_BIT, 1'b1);
        waitDrain(1'b0, 100);
        checkOutput("t5_data_after", {24'b0, data_f}, 32'h7E);
        driveRx(1'b0, 1'b1, 20);

        // Randomized mix of good frames, glitches and framing errors.
        for (int it = 0; it < 40; it++) begin
            r      = int'($urandom_range(0, 99));
            byte_v = 8'($urandom);
            if (r < 10) begin
                driveRx(1'b0, 1'b0, int'($urandom_range(1, 6)));
                driveRx(1'b0, 1'b1, int'($urandom_range(12, 30)));
            end else if (r < 18) begin
                applyStimulus(1'b0, byte_v, F_BIT, 1'b0);
                driveRx(1'b0, 1'b0, int'($urandom_range(0, 60)));
                driveRx(1'b0, 1'b1, int'($urandom_range(4, 20)));
            end else begin
                applyStimulus(1'b0, byte_v, F_BIT, 1'b1);
                driveRx(1'b0, 1'b1, int'($urandom_range(0, 20)));
            end
        end
        waitDrain(1'b0, 200);

        // Default rates: 0xC5 at nominal, slow and fast bit periods.
        driveRx(1'b1, 1'b1, 100);
        applyStimulus(1'b1, 8'hC5, 434, 1'b1);
        driveRx(1'b1, 1'b1, 434);
        waitDrain(1'b1, 1000);
        checkOutput("t6_data_434", {24'b0, data_d}, 32'hC5);
        applyStimulus(1'b1, 8'hC5, 430, 1'b1);
        driveRx(1'b1, 1'b1, 434);
        waitDrain(1'b1, 1000);
        checkOutput("t6_data_430", {24'b0, data_d}, 32'hC5);
        applyStimulus(1'b1, 8'hC5, 438, 1'b1);
        driveRx(1'b1, 1'b1, 434);
        waitDrain(1'b1, 1000);
        checkOutput("t6_data_438", {24'b0, data_d}, 32'hC5);
        for (int it = 0; it < 2; it++) begin
            byte_v = 8'($urandom);
            applyStimulus(1'b1, byte_v, 434, 1'b1);
            driveRx(1'b1, 1'b1, 434);
            waitDrain(1'b1, 1000);
        end

        checkOutput("queue_fast_empty", q_f.size(), 0);
        checkOutput("queue_def_empty", q_d.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
